// File: rtl/gearbox_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_pkg
// Shared definitions for the 2x gearbox pair (gearbox_upsizing_2x and
// gearbox_downsizing_2x): default beat size, a byte type and the FSM state
// encoding used by both width converters.
// -----------------------------------------------------------------------------
package gearbox_pkg;

  // Default number of bytes in a narrow beat; the wide word is twice this.
  localparam int N_DEFAULT = 5;

  typedef logic [7:0] byte_t;

  // EMPTY : nothing held
  // HI    : upper half of the held word is being presented
  // LO    : lower half of the held word is being presented
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } gb_state_e;

endpackage : gearbox_pkg

// File: rtl/gearbox_downsizing_2x.sv
// -----------------------------------------------------------------------------
// gearbox_downsizing_2x
// AXI-Stream width converter: each 2n-byte input word is emitted as two
// n-byte beats, upper half first, lower half second. Inverse of
// gearbox_upsizing_2x, so up->down chaining reproduces the byte stream.
//
// Ports
//   aclk        in   clock, all state on the rising edge
//   areset      in   asynchronous active-high reset
//   in_tdata    in   2*nb  wide word; [2nb-1:nb] goes out first
//   in_tvalid   in   input word valid
//   in_tready   out  input word accepted (combinational from state/out_tready)
//   in_tlast    in   word is last of packet
//   out_tdata   out  nb    narrow beat
//   out_tvalid  out  beat valid
//   out_tready  in   downstream accepts beat
//   out_tlast   out  beat is last of packet (lower half of a tlast word only)
// -----------------------------------------------------------------------------
module gearbox_downsizing_2x
  import gearbox_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [2*n*8-1:0]  in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic              in_tlast,
  output logic [n*8-1:0]    out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              out_tlast
);

  localparam int nb = n * 8;

  gb_state_e         r_state;
  logic [2*nb-1:0]   r_hold;
  logic              r_hold_last;
  logic [nb-1:0]     r_out_tdata;
  logic              r_out_tvalid;
  logic              r_out_tlast;

  logic              w_in_fire;

  // A new word can be taken when idle, or when the lower half is leaving
  // this cycle; the latter gives back-to-back words with no bubble.
  assign in_tready = ~areset & ((r_state == EMPTY) |
                                ((r_state == LO) & out_tready));
  assign w_in_fire = in_tvalid & in_tready;

  // Outputs are registered: they are updated together with the state so the
  // beat presented always matches the state that will be left on handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= EMPTY;
      r_hold       <= '0;
      r_hold_last  <= 1'b0;
      r_out_tdata  <= '0;
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_hold       <= in_tdata;
            r_hold_last  <= in_tlast;
            r_out_tdata  <= in_tdata[2*nb-1:nb];
            r_out_tvalid <= 1'b1;
            r_out_tlast  <= 1'b0;
            r_state      <= HI;
          end
        end

        HI: begin
          // Upper half accepted: present the lower half and the word's tlast.
          if (out_tready) begin
            r_out_tdata <= r_hold[nb-1:0];
            r_out_tlast <= r_hold_last;
            r_state     <= LO;
          end
        end

        LO: begin
          if (out_tready) begin
            if (w_in_fire) begin
              r_hold       <= in_tdata;
              r_hold_last  <= in_tlast;
              r_out_tdata  <= in_tdata[2*nb-1:nb];
              r_out_tvalid <= 1'b1;
              r_out_tlast  <= 1'b0;
              r_state      <= HI;
            end else begin
              // Data is left at the last held value so it is never X.
              r_out_tvalid <= 1'b0;
              r_out_tlast  <= 1'b0;
              r_state      <= EMPTY;
            end
          end
        end

        default: begin
          r_out_tvalid <= 1'b0;
          r_out_tlast  <= 1'b0;
          r_state      <= EMPTY;
        end
      endcase
    end
  end

  assign out_tdata  = r_out_tdata;
  assign out_tvalid = r_out_tvalid;
  assign out_tlast  = r_out_tlast;

endmodule : gearbox_downsizing_2x

// File: tb/tb_gearbox_downsizing_2x.sv
module tb_gearbox_downsizing_2x;
  import gearbox_pkg::*;

  localparam int N  = 5;
  localparam int NB = N * 8;
  localparam int WB = 2 * NB;
  localparam int RWORDS = 100;

  logic          aclk = 1'b0;
  logic          areset;
  logic [WB-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tready;
  logic          in_tlast;
  logic [NB-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic          out_tlast;

  logic man_ready, rnd_ready, rand_en;
  assign out_tready = rand_en ? rnd_ready : man_ready;

  always #5 aclk = ~aclk;

  gearbox_downsizing_2x #(.n(N)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [NB-1:0] d;
    logic          l;
  } beat_t;

  beat_t  exp_q[$];
  int     beat_cyc[$];
  logic   beat_last[$];
  byte_t  out_bytes[$];
  byte_t  in_bytes[RWORDS*2*N];

  function automatic void check(string name, logic [WB-1:0] act, logic [WB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge; a transfer happens on the next
  // rising edge when valid and ready are both high here.
  logic          prev_stall = 1'b0;
  logic [NB-1:0] prev_d;
  logic          prev_l;
  beat_t         mon_e;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_tvalid, 1'b1);
        check("stall_data", out_tdata, prev_d);
        check("stall_last", out_tlast, prev_l);
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", out_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", out_tdata, mon_e.d);
          check("beat_last", out_tlast, mon_e.l);
        end
        $display("[TB] beat cyc=%0d data=%h last=%b", cyc, out_tdata, out_tlast);
        beat_cyc.push_back(cyc);
        beat_last.push_back(out_tlast);
        for (int b = 0; b < N; b++) out_bytes.push_back(out_tdata[NB-1-8*b -: 8]);
      end
      prev_stall = out_tvalid && !out_tready;
      prev_d     = out_tdata;
      prev_l     = out_tlast;
    end
  end

  // Random out_tready: runs of 1..6 cycles at a random level.
  int rnd_cnt = 0;
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rnd_cnt == 0) begin
        rnd_ready = 1'($urandom_range(0, 1));
        rnd_cnt   = $urandom_range(1, 6);
      end
      rnd_cnt--;
    end
  end

  // Presents a word and waits for acceptance; returns at rising edge + 1
  // with in_tvalid still high so the caller may chain another word.
  task automatic send_word(input logic [WB-1:0] d, input logic l, output int waits);
    bit ok;
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    waits     = 0;
    ok        = 1'b0;
    while (!ok) begin
      @(negedge aclk);
      waits++;
      if (in_tready) ok = 1'b1;
      else if (waits > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no in_tready, expected acceptance within 200 cycles");
        break;
      end
    end
    if (ok) begin
      // Upper half first with tlast clear, then lower half carrying tlast.
      exp_q.push_back({d[WB-1:NB], 1'b0});
      exp_q.push_back({d[NB-1:0], l});
      $display("[TB] word cyc=%0d data=%h last=%b", cyc, d, l);
    end
    @(posedge aclk);
    #1;
    if (!ok) in_tvalid = 1'b0;
  endtask

  task automatic idle();
    in_tvalid = 1'b0;
    in_tdata  = '0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (k < 300 && !(exp_q.size() == 0 && !out_tvalid)) begin
      @(negedge aclk);
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_valid", out_tvalid, 1'b0);
    @(posedge aclk);
    #1;
  endtask

  int w;
  int nb0;
  int bad;
  logic [WB-1:0] word;

  initial begin
    areset    = 1'b1;
    man_ready = 1'b1;
    rand_en   = 1'b0;
    idle();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_valid", out_tvalid, 1'b0);
    check("rst_last", out_tlast, 1'b0);
    check("rst_data", out_tdata, '0);
    areset = 1'b0;
    #1;
    check("rst_in_ready", in_tready, 1'b1);
    @(posedge aclk);
    #1;

    // Single word
    send_word(80'h4142434445_464748494a, 1'b1, w);
    idle();
    check("t1_wait", w, 1);
    @(negedge aclk);
    check("t1_hi_valid", out_tvalid, 1'b1);
    check("t1_hi_data", out_tdata, 40'h4142434445);
    check("t1_hi_last", out_tlast, 1'b0);
    check("t1_hi_in_ready", in_tready, 1'b0);
    @(negedge aclk);
    check("t1_lo_valid", out_tvalid, 1'b1);
    check("t1_lo_data", out_tdata, 40'h464748494a);
    check("t1_lo_last", out_tlast, 1'b1);
    check("t1_lo_in_ready", in_tready, 1'b1);
    @(negedge aclk);
    check("t1_after_valid", out_tvalid, 1'b0);
    wait_drain();

    // Back-to-back: one accept every 2 cycles, 8 beats without gaps
    beat_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      send_word({8'h10 + 8'(i), 72'h0102030405060708_09 + 72'(i)}, 1'b0, w);
      check("b2b_wait", w, (i == 0) ? 1 : 2);
    end
    idle();
    wait_drain();
    check("b2b_beats", beat_cyc.size(), 8);
    if (beat_cyc.size() == 8) check("b2b_span", beat_cyc[7] - beat_cyc[0], 7);

    // Backpressure in HI
    beat_cyc.delete();
    man_ready = 1'b0;
    send_word(80'h4142434445_464748494a, 1'b1, w);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("bp_valid", out_tvalid, 1'b1);
      check("bp_data", out_tdata, 40'h4142434445);
      check("bp_in_ready", in_tready, 1'b0);
    end
    @(posedge aclk);
    #1;
    man_ready = 1'b1;
    wait_drain();
    check("bp_beats", beat_cyc.size(), 2);

    // Reset while the lower half is pending
    send_word(80'h4142434445_464748494a, 1'b1, w);
    idle();
    @(posedge aclk);
    #1;
    man_ready = 1'b0;
    check("rl_lo_pending", out_tvalid, 1'b1);
    #1;
    areset = 1'b1;
    #1;
    check("rl_valid_now", out_tvalid, 1'b0);
    exp_q.delete();
    @(posedge aclk);
    #1;
    areset    = 1'b0;
    man_ready = 1'b1;
    beat_cyc.delete();
    send_word(80'h4b4c4d4e4f_5051525354, 1'b1, w);
    idle();
    wait_drain();
    check("rl_beats", beat_cyc.size(), 2);

    // tlast mix
    beat_last.delete();
    send_word(80'h0a0b0c0d0e_0f10111213, 1'b0, w);
    send_word(80'h2122232425_2627282930, 1'b1, w);
    send_word(80'h3132333435_3637383940, 1'b0, w);
    idle();
    wait_drain();
    check("tl_beats", beat_last.size(), 6);
    if (beat_last.size() == 6)
      for (int i = 0; i < 6; i++) check("tl_last", beat_last[i], (i == 3) ? 1'b1 : 1'b0);

    // Random stalls and gaps over a packed byte stream
    out_bytes.delete();
    beat_cyc.delete();
    for (int i = 0; i < RWORDS*2*N; i++) in_bytes[i] = 8'($urandom);
    rand_en = 1'b1;
    for (int wi = 0; wi < RWORDS; wi++) begin
      for (int b = 0; b < 2*N; b++) word[WB-1-8*b -: 8] = in_bytes[wi*2*N + b];
      send_word(word, 1'($urandom_range(0, 1)), w);
      idle();
      nb0 = $urandom_range(0, 3);
      repeat (nb0) begin
        @(posedge aclk);
        #1;
      end
    end
    wait_drain();
    rand_en = 1'b0;
    check("rnd_beats", beat_cyc.size(), 2*RWORDS);
    check("rnd_bytes", out_bytes.size(), RWORDS*2*N);
    bad = 0;
    if (out_bytes.size() == RWORDS*2*N)
      for (int i = 0; i < RWORDS*2*N; i++) if (out_bytes[i] !== in_bytes[i]) bad++;
    check("rnd_stream_errors", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule : tb_gearbox_downsizing_2x
